// File: rtl/fpu_issue_sched.sv
// FP issue scheduler: RAW/WAW hazard blocking, fadd stage-enable control,
// fdiv/fsqrt start, and write-back port arbitration between fadd and divider.
module fpu_issue_sched (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ext_stall,
  input  logic       issue_valid,
  input  logic [1:0] issue_op,
  input  logic [4:0] issue_fs,
  input  logic [4:0] issue_ft,
  input  logic [4:0] issue_fd,
  output logic       issue_ready,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       div_start,
  input  logic       div_done,
  output logic       div_ack,
  output logic       wb_we,
  output logic       wb_sel,
  output logic [4:0] wb_fd
);

  logic       v_a, v_c, v_n;
  logic [4:0] fd_a, fd_c, fd_n;
  logic       div_pend;
  logic [4:0] div_fd;
  logic [1:0] div_wait;

  logic       is_div;
  logic       div_gnt;
  logic       adv;
  logic       hazard;
  logic       acc_add;
  logic       acc_div;

  // A register is busy if any in-flight producer (including one retiring now) targets it.
  function automatic logic reg_busy(input logic [4:0] r,
                                    input logic va, input logic [4:0] ta,
                                    input logic vc, input logic [4:0] tc,
                                    input logic vn, input logic [4:0] tn,
                                    input logic vd, input logic [4:0] td);
    return (va && (r == ta)) || (vc && (r == tc)) ||
           (vn && (r == tn)) || (vd && (r == td));
  endfunction

  always_comb begin
    is_div  = issue_op[1];
    div_gnt = clrn & div_done & (!v_n | (div_wait == 2'd3));
    adv     = !ext_stall & !(v_n & div_gnt);
    hazard  = reg_busy(issue_fs, v_a, fd_a, v_c, fd_c, v_n, fd_n, div_pend, div_fd) |
              reg_busy(issue_ft, v_a, fd_a, v_c, fd_c, v_n, fd_n, div_pend, div_fd) |
              reg_busy(issue_fd, v_a, fd_a, v_c, fd_c, v_n, fd_n, div_pend, div_fd);
    issue_ready = clrn & !ext_stall & !hazard & (is_div ? !div_pend : adv);
    acc_add   = issue_valid & issue_ready & !is_div;
    acc_div   = issue_valid & issue_ready & is_div;
    div_start = acc_div;
    e1 = adv;
    e2 = adv;
    e3 = adv;
    wb_we   = clrn & !ext_stall & (v_n | div_done);
    wb_sel  = div_gnt;
    wb_fd   = div_gnt ? div_fd : fd_n;
    div_ack = div_gnt & !ext_stall;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_a      <= 1'b0;
      v_c      <= 1'b0;
      v_n      <= 1'b0;
      fd_a     <= 5'd0;
      fd_c     <= 5'd0;
      fd_n     <= 5'd0;
      div_pend <= 1'b0;
      div_fd   <= 5'd0;
      div_wait <= 2'd0;
    end else begin
      // Stage boundary: issue -> align -> calc -> normalize, all under one enable.
      if (adv) begin
        v_a  <= acc_add;
        v_c  <= v_a;
        v_n  <= v_c;
        fd_c <= fd_a;
        fd_n <= fd_c;
        if (acc_add) fd_a <= issue_fd;
      end
      if (div_ack) begin
        div_pend <= 1'b0;
      end else if (acc_div) begin
        div_pend <= 1'b1;
        div_fd   <= issue_fd;
      end
      // Counts contested cycles the divider has lost so it cannot starve.
      if (div_ack) begin
        div_wait <= 2'd0;
      end else if (div_done && !div_gnt && !ext_stall && (div_wait != 2'd3)) begin
        div_wait <= div_wait + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: directed cycle checks plus
// write-back scoreboards for the fadd pipeline and the divider.
module tb_fpu_issue_sched;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ext_stall;
  logic       issue_valid;
  logic [1:0] issue_op;
  logic [4:0] issue_fs, issue_ft, issue_fd;
  logic       issue_ready;
  logic       e1, e2, e3;
  logic       div_start;
  logic       div_done;
  logic       div_ack;
  logic       wb_we;
  logic       wb_sel;
  logic [4:0] wb_fd;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] aq[$];
  logic [4:0] dq[$];

  fpu_issue_sched dut (
    .clk(clk), .clrn(clrn), .ext_stall(ext_stall),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
    .issue_ready(issue_ready), .e1(e1), .e2(e2), .e3(e3),
    .div_start(div_start), .div_done(div_done), .div_ack(div_ack),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_fd(wb_fd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd);
    issue_valid = v;
    issue_op    = op;
    issue_fs    = fs;
    issue_ft    = ft;
    issue_fd    = fd;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  // Scoreboard: every write-back is matched against the oldest expected
  // destination of the source it claims to come from.
  always @(negedge clk) begin
    if (wb_we) begin
      if (wb_sel) begin
        if (dq.size() == 0) chk("div_wb_unexpected", 1, 0);
        else chk("div_wb_fd", wb_fd, dq.pop_front());
        chk("div_ack_with_wb", div_ack, 1);
      end else begin
        if (aq.size() == 0) chk("add_wb_unexpected", 1, 0);
        else chk("add_wb_fd", wb_fd, aq.pop_front());
        chk("no_ack_on_add_wb", div_ack, 0);
      end
    end
  end

  initial begin
    clrn = 1'b0;
    ext_stall = 1'b0;
    div_done = 1'b0;
    idle();
    step();
    step();

    // Reset state, then an add presented in the release cycle.
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
    #1;
    chk("rst_ready", issue_ready, 0);
    chk("rst_en", {e1, e2, e3}, 3'b111);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_wb_fd", wb_fd, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_ack", div_ack, 0);
    clrn = 1'b1;
    #1;
    chk("rel_ready", issue_ready, 1);
    aq.push_back(5'd3);
    step();
    idle();
    #1;
    chk("s1_en_a", {e1, e2, e3}, 3'b111);
    step();
    chk("s1_en_c", {e1, e2, e3}, 3'b111);
    step();
    chk("s1_wb_we", wb_we, 1);
    chk("s1_wb_sel", wb_sel, 0);
    chk("s1_wb_fd", wb_fd, 3);
    chk("s1_en_n", {e1, e2, e3}, 3'b111);
    step();
    chk("s1_wb_done", wb_we, 0);

    // RAW hazard: dependent add waits until its producer has retired.
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd4);
    #1;
    chk("s2_a_ready", issue_ready, 1);
    aq.push_back(5'd4);
    step();
    drive(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6);
    #1;
    chk("s2_blk_a", issue_ready, 0);
    step();
    chk("s2_blk_c", issue_ready, 0);
    step();
    chk("s2_blk_n_retiring", issue_ready, 0);
    chk("s2_wb_fd", wb_fd, 4);
    step();
    chk("s2_b_ready", issue_ready, 1);
    aq.push_back(5'd6);
    step();
    drain(4);

    // Divider occupancy blocks the next div/sqrt until div_ack.
    drive(1'b1, OP_DIV, 5'd1, 5'd2, 5'd7);
    #1;
    chk("s3_div_ready", issue_ready, 1);
    chk("s3_div_start", div_start, 1);
    dq.push_back(5'd7);
    step();
    drive(1'b1, OP_DIV, 5'd3, 5'd4, 5'd8);
    #1;
    chk("s3_div2_blk", issue_ready, 0);
    chk("s3_no_start", div_start, 0);
    step();
    chk("s3_div2_blk2", issue_ready, 0);
    div_done = 1'b1;
    #1;
    chk("s3_ack7", div_ack, 1);
    chk("s3_sel7", wb_sel, 1);
    chk("s3_fd7", wb_fd, 7);
    chk("s3_blk_on_ack", issue_ready, 0);
    step();
    div_done = 1'b0;
    #1;
    chk("s3_div2_ready", issue_ready, 1);
    chk("s3_div2_start", div_start, 1);
    dq.push_back(5'd8);
    step();
    drive(1'b1, OP_SQRT, 5'd10, 5'd11, 5'd9);
    #1;
    chk("s3_sqrt_blk", issue_ready, 0);
    div_done = 1'b1;
    #1;
    chk("s3_ack8", div_ack, 1);
    step();
    div_done = 1'b0;
    #1;
    chk("s3_sqrt_ready", issue_ready, 1);
    chk("s3_sqrt_start", div_start, 1);
    dq.push_back(5'd9);
    step();
    drive(1'b1, OP_ADD, 5'd1, 5'd9, 5'd12);
    #1;
    chk("s3_ft_vs_div", issue_ready, 0);
    idle();
    div_done = 1'b1;
    #1;
    chk("s3_ack9", div_ack, 1);
    step();
    div_done = 1'b0;
    drain(2);

    // Divider starvation bound under a continuous add stream.
    drive(1'b1, OP_DIV, 5'd1, 5'd2, 5'd20);
    #1;
    chk("s4_div_ready", issue_ready, 1);
    dq.push_back(5'd20);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'(21 + i));
      if (i == 3) div_done = 1'b1;
      #1;
      if (i < 6) begin
        chk("s4_add_ready", issue_ready, 1);
        chk("s4_en", {e1, e2, e3}, 3'b111);
        aq.push_back(5'(21 + i));
        if (i >= 3) begin
          chk("s4_pipe_we", wb_we, 1);
          chk("s4_pipe_wins", wb_sel, 0);
        end
      end else begin
        chk("s4_hold_ready", issue_ready, 0);
        chk("s4_en_off", {e1, e2, e3}, 3'b000);
        chk("s4_div_wins", wb_sel, 1);
        chk("s4_div_fd", wb_fd, 20);
        chk("s4_div_ack", div_ack, 1);
      end
      step();
    end
    div_done = 1'b0;
    #1;
    chk("s4_resume_ready", issue_ready, 1);
    chk("s4_ack_once", div_ack, 0);
    chk("s4_en_back", {e1, e2, e3}, 3'b111);
    aq.push_back(5'd27);
    step();
    drain(6);

    // External stall freezes everything, including the starvation counter.
    drive(1'b1, OP_DIV, 5'd1, 5'd2, 5'd30);
    #1;
    chk("s5_div_ready", issue_ready, 1);
    dq.push_back(5'd30);
    step();
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd31);
    #1;
    chk("s5_add_ready", issue_ready, 1);
    aq.push_back(5'd31);
    step();
    idle();
    step();
    step();
    ext_stall = 1'b1;
    div_done = 1'b1;
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd32);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("s5_stall_we", wb_we, 0);
      chk("s5_stall_ack", div_ack, 0);
      chk("s5_stall_ready", issue_ready, 0);
      chk("s5_stall_en", {e1, e2, e3}, 3'b000);
      chk("s5_frozen_fd", wb_fd, 31);
      step();
    end
    ext_stall = 1'b0;
    #1;
    chk("s5_pipe_we", wb_we, 1);
    chk("s5_pipe_wins", wb_sel, 0);
    chk("s5_pipe_fd", wb_fd, 31);
    chk("s5_ready", issue_ready, 1);
    aq.push_back(5'd32);
    step();
    idle();
    #1;
    chk("s5_div_sel", wb_sel, 1);
    chk("s5_div_fd", wb_fd, 30);
    chk("s5_div_ack", div_ack, 1);
    chk("s5_div_en", {e1, e2, e3}, 3'b111);
    step();
    div_done = 1'b0;
    drain(5);

    // Asynchronous reset discards in-flight adds and the pending divide.
    drive(1'b1, OP_DIV, 5'd1, 5'd2, 5'd40);
    #1;
    chk("s6_div_ready", issue_ready, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'(41 + i));
      #1;
      chk("s6_add_ready", issue_ready, 1);
      step();
    end
    idle();
    clrn = 1'b0;
    #1;
    chk("s6_rst_we", wb_we, 0);
    chk("s6_rst_ready", issue_ready, 0);
    chk("s6_rst_en", {e1, e2, e3}, 3'b111);
    step();
    chk("s6_rst_we2", wb_we, 0);
    clrn = 1'b1;
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd41);
    #1;
    chk("s6_rel_ready", issue_ready, 1);
    aq.push_back(5'd41);
    step();
    drive(1'b1, OP_SQRT, 5'd1, 5'd41, 5'd40);
    #1;
    chk("s6_sqrt_ft_haz", issue_ready, 0);
    step();
    step();
    step();
    chk("s6_sqrt_ready", issue_ready, 1);
    chk("s6_sqrt_start", div_start, 1);
    dq.push_back(5'd40);
    step();
    idle();
    div_done = 1'b1;
    #1;
    chk("s6_ack", div_ack, 1);
    step();
    div_done = 1'b0;
    drain(3);

    chk("add_queue_empty", aq.size(), 0);
    chk("div_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Issue scheduler and write-back arbiter for the FPU. It accepts one FP instruction per cycle from the decode stage and tracks in-flight destinations to block RAW/WAW hazards. It drives the shared stage-register enables of the 3-stage pipelined fadd (align, calc, normalize) and starts the multi-cycle fdiv/fsqrt unit. It also arbitrates the single FP register-file write port between the fadd pipeline and the divider.

## Interface
- No parameters.
- clk  in  1  clock, all state updates on posedge.
- clrn  in  1  asynchronous active-low reset.
- ext_stall  in  1  CPU pipeline stall; freezes the scheduler.
- issue_valid  in  1  decode presents an FP op.
- issue_op  in  2  00 add, 01 sub, 10 div, 11 sqrt.
- issue_fs, issue_ft, issue_fd  in  5 each  source and destination FP register numbers.
- issue_ready  out  1  op accepted at this posedge when issue_valid is also high.
- e1, e2, e3  out  1 each  enables for the issue→align, align→calc and calc→norm stage registers.
- div_start  out  1  one-cycle pulse that starts a div/sqrt.
- div_done  in  1  divider result ready; held high until div_ack.
- div_ack  out  1  divider result written this cycle.
- wb_we  out  1  FP register-file write enable.
- wb_sel  out  1  0 = fadd normalize stage, 1 = divider.
- wb_fd  out  5  write-back destination.

## Operation
- State:
  - valid and fd tag for stages A, C and N (v_a/fd_a, v_c/fd_c, v_n/fd_n).
  - div_pend and div_fd.
  - div_wait, a 2-bit saturating counter.
- Reset (clrn low, asynchronous): every valid bit, tag, div_pend and div_wait clears to 0.
- Combinational outputs in reset:
  - e1..e3 = 1 (ext_stall low).
  - issue_ready, div_start, div_ack and wb_we = 0.
  - wb_sel = 0 and wb_fd = 0.
- Hazard: issue_fs, issue_ft or issue_fd equals the tag of any valid stage (A, C, N) or equals div_fd while div_pend is high.
  - A stage N entry retiring in the same cycle still counts as a hazard.
  - ft is checked for sqrt as well.
- Arbitration, when v_n and div_done are both high:
  - the pipeline wins while div_wait < 3;
  - the divider wins when div_wait == 3.
- If only one of v_n and div_done is high, that source wins.
- div_gnt means the divider holds the write port this cycle.
- adv = !ext_stall & !(v_n & div_gnt); e1 = e2 = e3 = adv.
- wb_we = !ext_stall & (v_n | div_done).
  - wb_sel = div_gnt.
  - wb_fd = div_gnt ? div_fd : fd_n.
- div_ack = div_gnt & !ext_stall.
- issue_ready = !ext_stall & !hazard, and additionally:
  - add/sub requires adv;
  - div/sqrt requires !div_pend.
- When adv is high, the stages shift: v_n<=v_a... i.e. v_a→v_c→v_n, with v_a loaded by an accepted add/sub (a bubble otherwise).
- When adv is low, all valid bits and tags hold.
- An accepted div/sqrt pulses div_start, sets div_pend and loads div_fd. div_ack clears div_pend.
- div_wait:
  - increments (saturating at 3) in each cycle with div_done & !div_gnt & !ext_stall;
  - clears on div_ack.
- ext_stall high: no acceptance, no write-back, no div_ack, no div_start; all state holds (div_wait included).

## Timing
- Add/sub accepted at edge k:
  - v_a high after edge k, v_c after k+1, v_n after k+2;
  - wb_we is asserted in the cycle after edge k+2, and the op retires at edge k+3 if it is granted and not stalled.
- Each cycle the pipeline loses arbitration adds one cycle of latency and holds the pipeline.
- Div/sqrt: div_start is high in the accept cycle. Write-back happens in the first granted cycle with div_done high.
- Back-to-back independent add/sub ops issue one per cycle.
- A dependent op issues in the cycle after its producer retires.
- Divider starvation is bounded: the divider waits at most 3 contested cycles.
- clrn asserted mid-operation discards all in-flight ops, with no write-back. An op presented in the reset-release cycle may be accepted in that cycle.

## Test plan
- Reset, then add fd=3 at edge 0 → e1..e3 high throughout; wb_we=1, wb_sel=0, wb_fd=3 in the cycle after edge 2.
- Add fd=4, then add fs=4 next cycle → second op held (issue_ready=0) until the cycle after the first retires, then accepted.
- Div fd=7, then div fd=8 → second op blocked until div_ack for fd=7. Then fsqrt fd=9 is accepted the cycle after div_ack.
- div_done held high under a continuous stream of independent adds:
  - the pipeline writes 3 times;
  - then div wins: wb_sel=1, wb_fd=div_fd, div_ack=1, e1..e3=0 for one cycle;
  - div_wait returns to 0.
- ext_stall high for 2 cycles with v_n=1 and div_done=1 → wb_we, div_ack and issue_ready all 0; state frozen; normal operation resumes afterwards.
- clrn pulsed low with three adds in flight and div_pend set → no wb_we afterwards; an op to the same fd is accepted immediately after release.
